// File: rtl/sparse_mac_pe.sv
// 2:4 structured-sparsity multiply-accumulate PE: mask-selected products are registered in S1,
// then reduced into a saturating accumulator whose total is emitted on the vector's last beat.
module sparse_mac_pe #(
    parameter int unsigned DW     = 4,
    parameter int unsigned GROUPS = 1,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [4*GROUPS*DW-1:0] act,
    input  logic [2*GROUPS*DW-1:0] wgt,
    input  logic [4*GROUPS-1:0]    mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_ovf
);

    localparam int unsigned NP = 2 * GROUPS;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = ACC_W + 1;

    logic                   stall;
    logic [GROUPS-1:0][4:0] dec;
    logic [NP-1:0][PW-1:0]  prod_d;
    logic                   beat_err;

    logic                   s1_valid;
    logic                   s1_last;
    logic                   s1_err;
    logic [NP-1:0][PW-1:0]  s1_prod;

    logic [ACC_W-1:0]       acc_q;
    logic                   err_q;
    logic                   ovf_q;

    logic [SW-1:0]          sum_full;
    logic [ACC_W-1:0]       sum_sat;
    logic                   sat_hit;

    // Returns {legal, hi_index, lo_index}; legal means exactly two bits set.
    function automatic logic [4:0] decode_mask(input logic [3:0] m);
        logic [2:0] cnt;
        logic [1:0] lo;
        logic [1:0] hi;
        cnt = '0;
        lo  = '0;
        hi  = '0;
        for (int e = 0; e < 4; e++) begin
            if (m[e]) begin
                if (cnt == 3'd0) lo = 2'(e);
                hi  = 2'(e);
                cnt = cnt + 3'd1;
            end
        end
        return {cnt == 3'd2, hi, lo};
    endfunction

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        dec = '0;
        for (int g = 0; g < GROUPS; g++) begin
            dec[g] = decode_mask(mask[4*g +: 4]);
        end
    end

    // Illegal groups leave both products at zero and flag the beat.
    always_comb begin
        prod_d   = '0;
        beat_err = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            if (dec[g][4]) begin
                prod_d[2*g]   = PW'(act[(4*g + int'(dec[g][1:0]))*DW +: DW]) *
                                PW'(wgt[(2*g)*DW +: DW]);
                prod_d[2*g+1] = PW'(act[(4*g + int'(dec[g][3:2]))*DW +: DW]) *
                                PW'(wgt[(2*g+1)*DW +: DW]);
            end else begin
                beat_err = 1'b1;
            end
        end
    end

    always_comb begin
        sum_full = SW'(acc_q);
        for (int i = 0; i < NP; i++) begin
            sum_full = sum_full + SW'(s1_prod[i]);
        end
        sat_hit = sum_full[ACC_W];
        sum_sat = sat_hit ? '1 : sum_full[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_err   <= beat_err;
            s1_prod  <= prod_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            if (s1_valid && s1_last) begin
                out_valid <= 1'b1;
                out_data  <= sum_sat;
                out_err   <= err_q | s1_err;
                out_ovf   <= ovf_q | sat_hit;
                acc_q     <= '0;
                err_q     <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                if (s1_valid) begin
                    acc_q <= sum_sat;
                    err_q <= err_q | s1_err;
                    ovf_q <= ovf_q | sat_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Bench for sparse_mac_pe: two instances (32-bit and 12-bit accumulators) share one stimulus
// stream; a reference model feeds per-instance scoreboards drained by a monitor process.
module tb_sparse_mac_pe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] act = '0;
    logic [7:0]  wgt = '0;
    logic [3:0]  mask = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_err_a, out_ovf_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_err_b, out_ovf_b;
    logic [11:0] out_data_b;

    typedef struct {
        longint data;
        bit     err;
        bit     ovf;
    } res_t;

    res_t   q_a[$];
    res_t   q_b[$];
    int     checks = 0;
    int     failures = 0;
    longint acc_a = 0, acc_b = 0;
    bit     err_v = 0, ovf_a = 0, ovf_b = 0;
    bit     rand_rdy = 0;
    logic [3:0] legal_masks[6] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};

    localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX_B = 64'd4095;

    sparse_mac_pe #(.DW(4), .GROUPS(1), .ACC_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_last(in_last), .act(act), .wgt(wgt), .mask(mask),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_err(out_err_a), .out_ovf(out_ovf_a)
    );

    sparse_mac_pe #(.DW(4), .GROUPS(1), .ACC_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .act(act), .wgt(wgt), .mask(mask),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_err(out_err_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: 2:4 dot product of the current beat, saturating running sum per accumulator width.
    task automatic model_accept();
        longint s = 0;
        int     pos[$];
        for (int e = 0; e < 4; e++) if (mask[e]) pos.push_back(e);
        if (pos.size() != 2) err_v = 1;
        else s = longint'(act[pos[0]*4 +: 4]) * longint'(wgt[3:0]) +
                 longint'(act[pos[1]*4 +: 4]) * longint'(wgt[7:4]);
        acc_a += s;
        if (acc_a > MAX_A) begin acc_a = MAX_A; ovf_a = 1; end
        acc_b += s;
        if (acc_b > MAX_B) begin acc_b = MAX_B; ovf_b = 1; end
        if (in_last) begin
            q_a.push_back('{data: acc_a, err: err_v, ovf: ovf_a});
            q_b.push_back('{data: acc_b, err: err_v, ovf: ovf_b});
            acc_a = 0; acc_b = 0; err_v = 0; ovf_a = 0; ovf_b = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] w, input logic [3:0] m,
                        input bit last);
        int n = 0;
        act = a; wgt = w; mask = m; in_last = last; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready_a) begin
                model_accept();
                tick();
                break;
            end
            tick();
            n++;
            if (n > 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy = 0;
        out_ready = 1'b1;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", q_a.size() + q_b.size(), 0);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_a"}, out_valid_a, 0);
        check({tag, "_data_a"}, out_data_a, 0);
        check({tag, "_err_a"}, out_err_a, 0);
        check({tag, "_ovf_a"}, out_ovf_a, 0);
        check({tag, "_valid_b"}, out_valid_b, 0);
        check({tag, "_data_b"}, out_data_b, 0);
        check({tag, "_ovf_b"}, out_ovf_b, 0);
        check({tag, "_in_ready"}, in_ready_a, 1);
    endtask

    // Monitor: scoreboard pop on each handshake, plus output stability while stalled.
    bit          held_a = 0, held_b = 0;
    logic [31:0] held_data_a;
    logic [11:0] held_data_b;
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            held_a = 0;
            held_b = 0;
        end else begin
            if (held_a) begin
                check("hold_valid_a", out_valid_a, 1);
                check("hold_data_a", out_data_a, held_data_a);
            end
            if (held_b) begin
                check("hold_valid_b", out_valid_b, 1);
                check("hold_data_b", out_data_b, held_data_b);
            end
            check("in_ready_rule", in_ready_a, !(out_valid_a && !out_ready));
            if (out_valid_a && out_ready) begin
                if (q_a.size() == 0) check("unexpected_result_a", 1, 0);
                else begin
                    r = q_a.pop_front();
                    check("data_a", out_data_a, r.data);
                    check("err_a", out_err_a, r.err);
                    check("ovf_a", out_ovf_a, r.ovf);
                end
            end
            if (out_valid_b && out_ready) begin
                if (q_b.size() == 0) check("unexpected_result_b", 1, 0);
                else begin
                    r = q_b.pop_front();
                    check("data_b", out_data_b, r.data);
                    check("err_b", out_err_b, r.err);
                    check("ovf_b", out_ovf_b, r.ovf);
                end
            end
            held_a = out_valid_a && !out_ready;
            held_b = out_valid_b && !out_ready;
            held_data_a = out_data_a;
            held_data_b = out_data_b;
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [3:0] m;
        bit         last;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // Single beat, with a latency check.
        send(16'h4321, 8'h57, 4'b0101, 1);
        check("lat_e0_valid", out_valid_a, 0);
        tick();
        check("lat_e1_valid", out_valid_a, 1);
        check("lat_e1_data", out_data_a, 22);
        drain();

        // Three-beat vector, then an accumulator-clear check.
        send(16'hFFFF, 8'hFF, 4'b1100, 0);
        send(16'hFFFF, 8'hFF, 4'b1100, 0);
        send(16'hFFFF, 8'hFF, 4'b1100, 1);
        send(16'h4321, 8'h57, 4'b0101, 1);
        drain();

        // Illegal mask sets the sticky error for that vector only.
        send(16'h4321, 8'h57, 4'b0101, 0);
        send(16'h4321, 8'h57, 4'b0111, 1);
        send(16'h4321, 8'h57, 4'b0101, 1);
        drain();

        // Backpressure.
        out_ready = 1'b0;
        send(16'h4321, 8'h57, 4'b0101, 1);
        send(16'hFFFF, 8'hFF, 4'b0011, 1);
        check("bp_in_ready", in_ready_a, 0);
        check("bp_data_22", out_data_a, 22);
        tick();
        check("bp_still_22", out_data_a, 22);
        out_ready = 1'b1;
        tick();
        check("bp_valid_kept", out_valid_a, 1);
        check("bp_data_450", out_data_a, 450);
        tick();
        check("bp_valid_drop", out_valid_a, 0);
        drain();

        // Saturation on the 12-bit instance.
        for (int i = 0; i < 10; i++) send(16'hFFFF, 8'hFF, 4'b1010, i == 9);
        send(16'h4321, 8'h57, 4'b0101, 1);
        drain();

        // Asynchronous reset mid-vector.
        send(16'hFFFF, 8'hFF, 4'b1100, 0);
        send(16'hFFFF, 8'hFF, 4'b1100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        acc_a = 0; acc_b = 0; err_v = 0; ovf_a = 0; ovf_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(16'h4321, 8'h57, 4'b0101, 1);
        drain();

        // Randomized traffic with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) != 0) m = legal_masks[$urandom_range(0, 5)];
            else m = 4'($urandom_range(0, 15));
            last = ($urandom_range(0, 2) == 0) || (i == 299);
            send(16'($urandom), 8'($urandom), m, last);
            if ($urandom_range(0, 7) == 0) tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
